// File: rtl/ustc_collector_pkg.sv
// rtl/ustc_collector_pkg.sv - shared FSM encoding and width constants for the FAN output collector
// Purpose : common types for ustc_collector and its sub-module.
// Contents: state_t (ST_ACCUM collects bus beats, ST_DRAIN serializes results),
//           ACC_GUARD (default accumulator headroom above the bus lane width).
package ustc_collector_pkg;

   typedef enum logic {
      ST_ACCUM = 1'b0,
      ST_DRAIN = 1'b1
   } state_t;

   // Headroom bits so a window of up to 2^ACC_GUARD full-scale beats cannot wrap.
   localparam int ACC_GUARD = 8;

endpackage

// File: rtl/ustc_collector_ffs.sv
// rtl/ustc_collector_ffs.sv - find-first-set over a lane mask (lowest set bit wins)
// Purpose : picks the next lane to drain and tells whether it is the last one.
// Ports   : i_vec    [N-1:0]  lane mask
//           o_index  [LW-1:0] index of lowest set bit (0 when i_vec is empty)
//           o_onehot [N-1:0]  one-hot of lowest set bit (0 when i_vec is empty)
//           o_single          i_vec has exactly one bit set
module ustc_collector_ffs #(
   parameter int N  = 62,
   parameter int LW = $clog2(N)
) (
   input  logic [N-1:0]  i_vec,
   output logic [LW-1:0] o_index,
   output logic [N-1:0]  o_onehot,
   output logic          o_single
);

   // Scan from the top down so the last hit written is the lowest set bit.
   always_comb begin
      o_index = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (i_vec[i]) begin
            o_index = LW'(i);
         end
      end
   end

   // x & -x isolates the lowest set bit; x & (x-1) clears it.
   assign o_onehot = i_vec & (~i_vec + N'(1));
   assign o_single = (i_vec != '0) && ((i_vec & (i_vec - N'(1))) == '0);

endmodule

// File: rtl/ustc_collector.sv
// rtl/ustc_collector.sv - FAN reduction bus collector: per-lane window accumulate, then serialize
// Purpose : accumulates the FAN tree partial-sum lanes over one window of beats and streams out
//           {lane, sum} for every lane that received data, lowest lane first.
// Ports   : clk, reset_n (async, active low)
//           enable, in_strobe, in_bus, in_valid, in_first, in_last  - input beat
//           in_ready                                                - high while collecting (ACCUM)
//           out_valid, out_ready, out_lane, out_data, out_last      - result stream
//           win_done    - one-cycle pulse when a window has fully drained (or was empty)
//           err_overrun - sticky, a beat was strobed while in_ready was low
module ustc_collector
   import ustc_collector_pkg::*;
#(
   parameter int N_UNIT    = 32,
   parameter int N_ADDERS  = N_UNIT - 1,
   parameter int N_BUSLINE = 2 * N_ADDERS,
   parameter int DW_DATA   = 32,
   parameter int DW_ACC    = DW_DATA + ACC_GUARD,
   parameter int LW        = $clog2(N_BUSLINE)
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic                         enable,
   input  logic                         in_strobe,
   input  logic [N_BUSLINE*DW_DATA-1:0] in_bus,
   input  logic [N_BUSLINE-1:0]         in_valid,
   input  logic                         in_first,
   input  logic                         in_last,
   output logic                         in_ready,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [LW-1:0]                out_lane,
   output logic [DW_ACC-1:0]            out_data,
   output logic                         out_last,
   output logic                         win_done,
   output logic                         err_overrun
);

   state_t                    r_state;
   state_t                    w_state_next;
   logic signed [DW_ACC-1:0]  r_acc [N_BUSLINE];
   logic [N_BUSLINE-1:0]      r_mask;
   logic                      r_win_done;
   logic                      r_err;

   logic signed [DW_ACC-1:0]  w_lane_ext [N_BUSLINE];
   logic [N_BUSLINE-1:0]      w_mask_acc;
   logic                      w_accept;
   logic                      w_overrun;
   logic                      w_handshake;
   logic                      w_win_done_next;
   logic [LW-1:0]             w_ffs_index;
   logic [N_BUSLINE-1:0]      w_ffs_onehot;
   logic                      w_ffs_single;

   // Sign-extend each bus lane to accumulator width.
   for (genvar g = 0; g < N_BUSLINE; g++) begin : g_lane
      assign w_lane_ext[g] = DW_ACC'($signed(in_bus[g*DW_DATA +: DW_DATA]));
   end

   assign w_accept    = enable & in_strobe & (r_state == ST_ACCUM);
   assign w_overrun   = enable & in_strobe & (r_state != ST_ACCUM);
   assign w_handshake = (r_state == ST_DRAIN) & out_ready;

   // Mask as it will stand after this beat; decides DRAIN vs empty-window.
   assign w_mask_acc = in_first ? in_valid : (r_mask | in_valid);

   ustc_collector_ffs #(
      .N  (N_BUSLINE),
      .LW (LW)
   ) u_ffs (
      .i_vec    (r_mask),
      .o_index  (w_ffs_index),
      .o_onehot (w_ffs_onehot),
      .o_single (w_ffs_single)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= ST_ACCUM;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next    = r_state;
      w_win_done_next = 1'b0;
      case (r_state)
         ST_ACCUM: begin
            if (w_accept && in_last) begin
               if (|w_mask_acc) begin
                  w_state_next = ST_DRAIN;
               end else begin
                  w_win_done_next = 1'b1;
               end
            end
         end
         ST_DRAIN: begin
            if (w_handshake && w_ffs_single) begin
               w_state_next    = ST_ACCUM;
               w_win_done_next = 1'b1;
            end
         end
         default: w_state_next = ST_ACCUM;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_mask <= '0;
      end else if (w_accept) begin
         r_mask <= w_mask_acc;
      end else if (w_handshake) begin
         r_mask <= r_mask & ~w_ffs_onehot;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < N_BUSLINE; i++) begin
            r_acc[i] <= '0;
         end
      end else if (w_accept) begin
         for (int i = 0; i < N_BUSLINE; i++) begin
            if (in_first) begin
               r_acc[i] <= in_valid[i] ? w_lane_ext[i] : '0;
            end else if (in_valid[i]) begin
               r_acc[i] <= r_acc[i] + w_lane_ext[i];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_win_done <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         r_win_done <= w_win_done_next;
         if (w_overrun) begin
            r_err <= 1'b1;
         end
      end
   end

   // All outputs come from registered state only.
   assign in_ready    = (r_state == ST_ACCUM);
   assign out_valid   = (r_state == ST_DRAIN);
   assign out_lane    = w_ffs_index;
   assign out_data    = r_acc[w_ffs_index];
   assign out_last    = w_ffs_single;
   assign win_done    = r_win_done;
   assign err_overrun = r_err;

endmodule

// File: tb/tb_ustc_collector.sv
// tb/tb_ustc_collector.sv - randomized self-checking bench for ustc_collector
module tb_ustc_collector;

   localparam int NB = 62;
   localparam int DW = 32;
   localparam int DA = 40;
   localparam int NW = 6;

   typedef struct packed {
      logic [5:0]    lane;
      logic [DA-1:0] data;
   } exp_t;

   logic              clk = 1'b0;
   logic              reset_n = 1'b0;
   logic              enable = 1'b0;
   logic              in_strobe = 1'b0;
   logic [NB*DW-1:0]  in_bus = '0;
   logic [NB-1:0]     in_valid = '0;
   logic              in_first = 1'b0;
   logic              in_last = 1'b0;
   logic              out_ready = 1'b0;
   logic              in_ready, out_valid, out_last, win_done, err_overrun;
   logic [5:0]        out_lane;
   logic [DA-1:0]     out_data;

   logic              tw_enable = 1'b0;
   logic              tw_strobe = 1'b0;
   logic [NW*DW-1:0]  tw_bus = '0;
   logic [NW-1:0]     tw_valid = '0;
   logic              tw_first = 1'b0;
   logic              tw_last = 1'b0;
   logic              tw_out_ready = 1'b0;
   logic              tw_in_ready, tw_out_valid, tw_out_last, tw_win_done, tw_err;
   logic [2:0]        tw_out_lane;
   logic [31:0]       tw_out_data;

   int     n_checks = 0;
   int     n_errors = 0;
   longint m_acc [NB];
   bit     m_mask [NB];
   int     beat_data [NB];
   bit     exp_err = 1'b0;
   exp_t   exp_q [$];

   always #5 clk = ~clk;

   ustc_collector u_dut (
      .clk(clk), .reset_n(reset_n), .enable(enable), .in_strobe(in_strobe),
      .in_bus(in_bus), .in_valid(in_valid), .in_first(in_first), .in_last(in_last),
      .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
      .out_lane(out_lane), .out_data(out_data), .out_last(out_last),
      .win_done(win_done), .err_overrun(err_overrun)
   );

   ustc_collector #(.N_UNIT(4), .DW_ACC(32)) u_dut_wrap (
      .clk(clk), .reset_n(reset_n), .enable(tw_enable), .in_strobe(tw_strobe),
      .in_bus(tw_bus), .in_valid(tw_valid), .in_first(tw_first), .in_last(tw_last),
      .in_ready(tw_in_ready), .out_valid(tw_out_valid), .out_ready(tw_out_ready),
      .out_lane(tw_out_lane), .out_data(tw_out_data), .out_last(tw_out_last),
      .win_done(tw_win_done), .err_overrun(tw_err)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < NB; i++) begin
         m_acc[i]  = 0;
         m_mask[i] = 1'b0;
      end
      exp_q.delete();
   endtask

   // One beat; optionally preceded by a strobe with enable low that must be ignored.
   task automatic send_beat(input bit first, input bit last, input logic [NB-1:0] vmask, input bit idle);
      for (int i = 0; i < NB; i++) in_bus[i*DW +: DW] = beat_data[i];
      in_valid  = vmask;
      in_first  = first;
      in_last   = last;
      in_strobe = 1'b1;
      if (idle) begin
         enable = 1'b0;
         @(posedge clk); #1;
         check("idle_in_ready", in_ready, 1);
         check("idle_out_valid", out_valid, 0);
         check("idle_err", err_overrun, exp_err);
      end
      enable = 1'b1;
      @(posedge clk); #1;
      in_strobe = 1'b0; in_first = 1'b0; in_last = 1'b0; in_valid = '0;
      for (int i = 0; i < NB; i++) begin
         if (first) begin
            m_acc[i]  = vmask[i] ? longint'(beat_data[i]) : 0;
            m_mask[i] = vmask[i];
         end else if (vmask[i]) begin
            m_acc[i]  = m_acc[i] + longint'(beat_data[i]);
            m_mask[i] = 1'b1;
         end
      end
      exp_q.delete();
      if (last) begin
         for (int i = 0; i < NB; i++) begin
            if (m_mask[i]) exp_q.push_back({6'(i), DA'(m_acc[i])});
            m_mask[i] = 1'b0;
         end
         if (exp_q.size() == 0) begin
            check("empty_win_done", win_done, 1);
            check("empty_out_valid", out_valid, 0);
            check("empty_in_ready", in_ready, 1);
            @(posedge clk); #1;
            check("empty_win_done_drop", win_done, 0);
            check("empty_in_ready2", in_ready, 1);
         end else begin
            check("drain_latency_valid", out_valid, 1);
            check("drain_in_ready", in_ready, 0);
         end
      end else begin
         check("mid_in_ready", in_ready, 1);
         check("mid_out_valid", out_valid, 0);
      end
   endtask

   // Drain expected results with random backpressure; bp forces 5 stalled cycles
   // and strobes a stray beat into DRAIN.
   task automatic drain(input bit bp);
      int cyc = 0;
      bit rdy;
      while (exp_q.size() > 0 && cyc < 400) begin
         check("out_valid", out_valid, 1);
         check("out_lane", out_lane, exp_q[0].lane);
         check("out_data", out_data, exp_q[0].data);
         check("out_last", out_last, (exp_q.size() == 1));
         check("err_overrun", err_overrun, exp_err);
         rdy = (bp && cyc < 5) ? 1'b0 : ($urandom_range(0, 3) != 0);
         out_ready = rdy;
         if (bp && cyc == 2) begin
            for (int i = 0; i < NB; i++) in_bus[i*DW +: DW] = $urandom;
            in_valid = '1; in_first = 1'b1; in_last = 1'b1;
            enable = 1'b1; in_strobe = 1'b1;
         end
         @(posedge clk); #1;
         in_strobe = 1'b0; in_first = 1'b0; in_last = 1'b0; in_valid = '0;
         if (bp && cyc == 2) exp_err = 1'b1;
         cyc++;
         if (rdy) void'(exp_q.pop_front());
      end
      out_ready = 1'b0;
      check("drain_timeout", exp_q.size(), 0);
      check("done_win_done", win_done, 1);
      check("done_out_valid", out_valid, 0);
      check("done_in_ready", in_ready, 1);
      check("done_err", err_overrun, exp_err);
      @(posedge clk); #1;
      check("done_win_done_drop", win_done, 0);
   endtask

   task automatic clear_data();
      for (int i = 0; i < NB; i++) beat_data[i] = 0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [NB-1:0] v;
      int nbeats;

      model_clear();
      repeat (2) @(posedge clk);
      #1;
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_win_done", win_done, 0);
      check("rst_err", err_overrun, 0);
      reset_n = 1'b1;
      @(posedge clk); #1;
      check("rel_in_ready", in_ready, 1);
      check("rel_out_valid", out_valid, 0);
      check("rel_win_done", win_done, 0);
      check("rel_err", err_overrun, 0);

      // Single-beat window, negative lane sign-extended.
      clear_data();
      beat_data[3] = 5; beat_data[10] = -7;
      v = '0; v[3] = 1'b1; v[10] = 1'b1;
      send_beat(1'b1, 1'b1, v, 1'b0);
      check("neg_sext_expect", exp_q[1].data, 40'hFF_FFFF_FFF9);
      drain(1'b0);

      // Three-beat accumulation.
      clear_data(); beat_data[0] = 100;
      v = '0; v[0] = 1'b1;
      send_beat(1'b1, 1'b0, v, 1'b0);
      beat_data[0] = 200; beat_data[61] = 32'h7FFF_FFFF;
      v[61] = 1'b1;
      send_beat(1'b0, 1'b0, v, 1'b0);
      clear_data(); beat_data[0] = -50;
      v = '0; v[0] = 1'b1;
      send_beat(1'b0, 1'b1, v, 1'b1);
      drain(1'b0);

      // Backpressure with stray beat into DRAIN.
      clear_data(); beat_data[7] = 11; beat_data[20] = -3; beat_data[40] = 99;
      v = '0; v[7] = 1'b1; v[20] = 1'b1; v[40] = 1'b1;
      send_beat(1'b1, 1'b1, v, 1'b0);
      drain(1'b1);

      // Empty window.
      clear_data();
      send_beat(1'b1, 1'b1, '0, 1'b0);

      // Randomized windows.
      for (int w = 0; w < 14; w++) begin
         nbeats = $urandom_range(1, 4);
         for (int b = 0; b < nbeats; b++) begin
            for (int i = 0; i < NB; i++) beat_data[i] = int'($urandom);
            v = NB'({$urandom, $urandom});
            if ($urandom_range(0, 1) == 0) v = v & NB'({$urandom, $urandom});
            if ($urandom_range(0, 5) == 0) v = '0;
            send_beat(b == 0, b == nbeats - 1, v, $urandom_range(0, 3) == 0);
         end
         if (exp_q.size() > 0) drain($urandom_range(0, 4) == 0);
      end

      // Async reset in the middle of a drain.
      clear_data(); beat_data[1] = 1; beat_data[2] = 2; beat_data[3] = 3;
      v = '0; v[1] = 1'b1; v[2] = 1'b1; v[3] = 1'b1;
      send_beat(1'b1, 1'b1, v, 1'b0);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check("mid_drain_lane", out_lane, 2);
      #2 reset_n = 1'b0;
      #1;
      check("async_rst_out_valid", out_valid, 0);
      check("async_rst_in_ready", in_ready, 1);
      check("async_rst_err", err_overrun, 0);
      exp_err = 1'b0;
      model_clear();
      @(posedge clk); #1;
      reset_n = 1'b1;
      @(posedge clk); #1;
      clear_data(); beat_data[5] = 9;
      v = '0; v[5] = 1'b1;
      send_beat(1'b1, 1'b1, v, 1'b0);
      drain(1'b0);

      // Accumulator wrap in a DW_ACC == DW_DATA build.
      tw_out_ready = 1'b1;
      tw_bus = '0; tw_bus[31:0] = 32'h7FFF_FFFF;
      tw_valid = 6'b000001; tw_first = 1'b1; tw_enable = 1'b1; tw_strobe = 1'b1;
      @(posedge clk); #1;
      tw_bus[31:0] = 32'h0000_0001; tw_first = 1'b0; tw_last = 1'b1;
      @(posedge clk); #1;
      tw_strobe = 1'b0; tw_last = 1'b0; tw_valid = '0;
      check("wrap_valid", tw_out_valid, 1);
      check("wrap_lane", tw_out_lane, 0);
      check("wrap_data", tw_out_data, 32'h8000_0000);
      check("wrap_last", tw_out_last, 1);
      @(posedge clk); #1;
      check("wrap_win_done", tw_win_done, 1);
      check("wrap_out_valid_drop", tw_out_valid, 0);
      check("wrap_err", tw_err, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
